// File: rtl/mips_pkg.sv
// Shared core-wide sizing for the physical register file and rename
// structures (free list, FRAT, RRAT, busybits).
package mips_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int TAG_W    = 6;

  // Free list holds every physical register not mapped architecturally.
  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W = $clog2(DEPTH);
  // Index plus one wrap bit so full and empty are distinguishable.
  localparam int PTR_W = IDX_W + 1;

  typedef logic [TAG_W-1:0] phys_reg_t;

endpackage

// File: rtl/fl_ptr.sv
// Wrapping circular-buffer pointer (index + wrap bit).
// Reset has priority over load, load over increment; arithmetic wraps
// modulo 2**W, so the top bit toggles on index rollover.
module fl_ptr #(
  parameter int         W       = 6,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer: load wins over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (ld_i)       ptr_d = ld_val_i;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= RST_VAL;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/free_list.sv
// Physical-register free list: hands unallocated IDs to the FRAT, takes
// back IDs freed by the RRAT at retirement, and rewinds speculative
// allocations to the commit pointer on SYS.
// Optional feature: define FREELIST_BYPASS_EN to forward a freed ID
// straight to the FRAT when the list is empty.
module free_list #(
  parameter int NUM_PHYS = mips_pkg::NUM_PHYS,
  parameter int NUM_ARCH = mips_pkg::NUM_ARCH,
  parameter int TAG_W    = mips_pkg::TAG_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SYS,
  input  logic             Shift_IN_FRAT,
  input  logic             STALL_IN_FRAT,
  input  logic [TAG_W-1:0] RegID_IN_RRAT,
  input  logic             enable_IN_RRAT,
  input  logic             Commit_IN_RRAT,
  output logic [TAG_W-1:0] RegID_OUT_FRAT,
  output logic             STALL_OUT_FRAT,
  output logic             ERR_OUT
);

  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, cm_ptr, cm_nxt;
  logic             err_q, err_d;
  logic             empty, full, bypass;
  logic             pop_req, pop, push, commit_ok;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                 (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

`ifdef FREELIST_BYPASS_EN
  // Empty list with a freed ID arriving: forward it to the FRAT directly.
  assign bypass = empty & enable_IN_RRAT;
`else
  assign bypass = 1'b0;
`endif

  assign pop_req   = Shift_IN_FRAT & ~STALL_IN_FRAT;
  // SYS rewinds rd_ptr, so no pop is taken in a flush cycle.
  assign pop       = pop_req & ~SYS & (~empty | bypass);
  assign push      = enable_IN_RRAT & ~full;
  // Committing more IDs than were allocated is a protocol error.
  assign commit_ok = Commit_IN_RRAT & (cm_ptr != rd_ptr);
  assign cm_nxt    = commit_ok ? cm_ptr + PTR_W'(1) : cm_ptr;

  // Sticky error: underflow pop, overflow push, over-commit.
  always_comb begin
    err_d = err_q;
    if (pop_req & ~SYS & empty & ~bypass) err_d = 1'b1;
    if (enable_IN_RRAT & full)            err_d = 1'b1;
    if (Commit_IN_RRAT & ~commit_ok)      err_d = 1'b1;
  end

  // Error flag register; cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  // ID storage: reset image holds NUM_ARCH..NUM_PHYS-1, pushes overwrite.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(NUM_ARCH + i);
    end else if (push) begin
      mem_q[wr_ptr[IDX_W-1:0]] <= RegID_IN_RRAT;
    end
  end

  fl_ptr #(.W(PTR_W), .RST_VAL('0)) u_rd_ptr (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .ld_i     (SYS),
    .ld_val_i (cm_nxt),
    .inc_i    (pop),
    .ptr_o    (rd_ptr)
  );

  // Reset image is a full list: wr sits one lap ahead of rd.
  fl_ptr #(.W(PTR_W), .RST_VAL(PTR_W'(DEPTH))) u_wr_ptr (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (push),
    .ptr_o    (wr_ptr)
  );

  fl_ptr #(.W(PTR_W), .RST_VAL('0)) u_cm_ptr (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (commit_ok),
    .ptr_o    (cm_ptr)
  );

  assign RegID_OUT_FRAT = bypass ? RegID_IN_RRAT : mem_q[rd_ptr[IDX_W-1:0]];
  assign STALL_OUT_FRAT = empty & ~bypass;
  assign ERR_OUT        = err_q;

endmodule
